// File: rtl/crc_pkg.sv
// Shared definitions for the memory CRC checker.
//   crc_state_e      : checker FSM states
//   Crc16*           : USB-16 default polynomial / preset / output mask
//   crc_reflect      : bit-reverse the low `width` bits of a value
//   crc_update_byte  : absorb one byte MSB-first into a CRC of `width` bits
// Functions work on 32-bit containers so any CRC_W up to 32 can share them.
package crc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } crc_state_e;

  localparam logic [15:0] Crc16Poly   = 16'h8005;
  localparam logic [15:0] Crc16Init   = 16'hFFFF;
  localparam logic [15:0] Crc16XorOut = 16'hFFFF;

  function automatic logic [31:0] crc_reflect(input logic [31:0] value,
                                              input int unsigned width);
    logic [31:0] rev;
    rev = {<<{value}};
    // Full 32-bit reversal leaves the wanted bits at the top; shift them down.
    return rev >> (32 - width);
  endfunction

  function automatic logic [31:0] crc_update_byte(input logic [31:0] crc,
                                                  input logic [7:0]  data,
                                                  input logic [31:0] poly,
                                                  input int unsigned width);
    logic [31:0] c;
    logic [31:0] top;
    logic [31:0] mask;
    logic [7:0]  d;
    logic        fb;
    top  = 32'd1 << (width - 1);
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    c    = crc & mask;
    d    = data;
    for (int i = 0; i < 8; i++) begin
      fb = ((c & top) != 32'd0) ^ d[7];
      c  = (c << 1) & mask;
      if (fb) begin
        c = c ^ (poly & mask);
      end
      d = d << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_byte_engine.sv
// CRC register with byte-wide update.
//   clk50m  : clock, rising edge
//   rst_n   : synchronous active-low reset (register -> INIT)
//   clear   : preset register to INIT (wins over enable)
//   enable  : absorb data_in this cycle
//   data_in : input byte, optionally bit-reflected before absorption
//   crc     : current raw CRC register (no output reflection / mask)
module crc_byte_engine
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(Crc16Poly),
  parameter logic [CRC_W-1:0] INIT    = CRC_W'(Crc16Init),
  parameter int unsigned      REFLECT = 1
) (
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [7:0]       data_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q, crc_d;
  logic [7:0]       byte_in;

  always_comb begin
    byte_in = (REFLECT != 0) ? 8'(crc_reflect({24'h0, data_in}, 8)) : data_in;
    crc_d   = crc_q;
    if (clear) begin
      crc_d = INIT;
    end else if (enable) begin
      crc_d = CRC_W'(crc_update_byte(32'(crc_q), byte_in, 32'(POLY), CRC_W));
    end
  end

  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc_mem_checker.sv
// Reads `length` bytes from a latency-MEM_LAT byte memory starting at
// `base_addr`, computes their CRC and compares it to `crc_target`.
//   clk50m, rst_n        : clock and synchronous active-low reset
//   crc_start            : start request (accepted in idle only)
//   base_addr, length    : run descriptor, latched at start
//   crc_target           : expected CRC, compared in the completion cycle
//   abort                : cancel the current run, results untouched
//   mem_addr/mem_rd      : read request, one byte per cycle
//   mem_data             : read data, MEM_LAT cycles after mem_rd
//   busy                 : any state other than idle
//   crc_rdy              : one-cycle completion pulse
//   crc_ok, crc_out      : result, held between runs
module crc_mem_checker
  import crc_pkg::*;
#(
  parameter int unsigned      ADDR_W  = 10,
  parameter int unsigned      CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(Crc16Poly),
  parameter logic [CRC_W-1:0] INIT    = CRC_W'(Crc16Init),
  parameter logic [CRC_W-1:0] XOR_OUT = CRC_W'(Crc16XorOut),
  parameter int unsigned      REFLECT = 1,
  parameter int unsigned      MEM_LAT = 1
) (
  input  logic              clk50m,
  input  logic              rst_n,
  input  logic              crc_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [CRC_W-1:0]  crc_target,
  input  logic              abort,
  input  logic [7:0]        mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              busy,
  output logic              crc_rdy,
  output logic              crc_ok,
  output logic [CRC_W-1:0]  crc_out
);

  // Pipe pattern where only the oldest (qualifying) slot is still occupied.
  localparam logic [MEM_LAT-1:0] VldLast = MEM_LAT'(1) << (MEM_LAT - 1);
  localparam logic [ADDR_W:0]    CntOne  = (ADDR_W + 1)'(1);

  crc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [MEM_LAT-1:0] vld_q, vld_d;
  logic [CRC_W-1:0]  out_q, out_d;
  logic              ok_q, ok_d;
  logic              crc_clear;
  logic              byte_vld;
  logic [CRC_W-1:0]  crc_val;
  logic [CRC_W-1:0]  final_crc;

  assign mem_rd   = (state_q == StFetch);
  assign mem_addr = base_q + cnt_q[ADDR_W-1:0];
  assign busy     = (state_q != StIdle);
  assign byte_vld = vld_q[MEM_LAT-1];

  assign final_crc = ((REFLECT != 0) ? CRC_W'(crc_reflect(32'(crc_val), CRC_W)) : crc_val)
                     ^ XOR_OUT;

  crc_byte_engine #(
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .INIT   (INIT),
    .REFLECT(REFLECT)
  ) u_engine (
    .clk50m (clk50m),
    .rst_n  (rst_n),
    .clear  (crc_clear),
    .enable (byte_vld),
    .data_in(mem_data),
    .crc    (crc_val)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    ok_d      = ok_q;
    crc_clear = 1'b0;
    crc_rdy   = 1'b0;
    // Oldest slot drops off the top; this cycle's issue enters at bit 0.
    vld_d     = MEM_LAT'({vld_q, mem_rd});

    unique case (state_q)
      StIdle: begin
        if (crc_start) begin
          crc_clear = 1'b1;
          base_d    = base_addr;
          len_d     = length;
          cnt_d     = '0;
          state_d   = (length == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_q + CntOne == len_q) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Nothing new enters the pipe here, so a lone top bit is the last byte.
        if (vld_q == VldLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        crc_rdy = 1'b1;
        out_d   = final_crc;
        ok_d    = (final_crc == crc_target);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      vld_d   = '0;
      crc_rdy = 1'b0;
      out_d   = out_q;
      ok_d    = ok_q;
    end
  end

  // Results are presented in the DONE cycle itself and captured for holding.
  assign crc_out = out_d;
  assign crc_ok  = ok_d;

  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      state_q <= StIdle;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      out_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
      ok_q    <= ok_d;
    end
  end

endmodule

// File: tb/tb_crc_mem_checker.sv
// Drives three checker instances (USB-16 latency 1, ARC latency 1, USB-16
// latency 3) with identical run requests and checks each against a
// table-free reflected (LSB-first) CRC model and cycle expectations.
module tb_crc_mem_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base;
  logic [10:0] len;
  logic        abort;
  logic [15:0] target [3];
  logic [7:0]  mdata  [3];
  logic [9:0]  maddr  [3];
  logic [2:0]  mrd, busy, rdy, ok;
  logic [15:0] cout   [3];

  logic [7:0]  mem [1024];
  logic [7:0]  pipe0, pipe1;
  logic [7:0]  pipe2 [3];

  int          lat_p  [3] = '{1, 1, 3};
  logic [15:0] init_p [3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
  logic [15:0] xor_p  [3] = '{16'hFFFF, 16'h0000, 16'hFFFF};

  logic [15:0] hold_out [3];
  logic        hold_ok  [3];
  logic [15:0] last_out [3];
  int          last_rdy_c [3];

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  crc_mem_checker u_usb (
    .clk50m(clk), .rst_n(rst_n), .crc_start(start), .base_addr(base), .length(len),
    .crc_target(target[0]), .abort(abort), .mem_data(mdata[0]), .mem_addr(maddr[0]),
    .mem_rd(mrd[0]), .busy(busy[0]), .crc_rdy(rdy[0]), .crc_ok(ok[0]), .crc_out(cout[0])
  );

  crc_mem_checker #(.INIT(16'h0000), .XOR_OUT(16'h0000)) u_arc (
    .clk50m(clk), .rst_n(rst_n), .crc_start(start), .base_addr(base), .length(len),
    .crc_target(target[1]), .abort(abort), .mem_data(mdata[1]), .mem_addr(maddr[1]),
    .mem_rd(mrd[1]), .busy(busy[1]), .crc_rdy(rdy[1]), .crc_ok(ok[1]), .crc_out(cout[1])
  );

  crc_mem_checker #(.MEM_LAT(3)) u_lat3 (
    .clk50m(clk), .rst_n(rst_n), .crc_start(start), .base_addr(base), .length(len),
    .crc_target(target[2]), .abort(abort), .mem_data(mdata[2]), .mem_addr(maddr[2]),
    .mem_rd(mrd[2]), .busy(busy[2]), .crc_rdy(rdy[2]), .crc_ok(ok[2]), .crc_out(cout[2])
  );

  // Memory models: data for the address of cycle k appears in cycle k+latency.
  always @(posedge clk) begin
    pipe0    <= mem[maddr[0]];
    pipe1    <= mem[maddr[1]];
    pipe2[0] <= mem[maddr[2]];
    pipe2[1] <= pipe2[0];
    pipe2[2] <= pipe2[1];
  end
  assign mdata[0] = pipe0;
  assign mdata[1] = pipe1;
  assign mdata[2] = pipe2[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic string tg(input string name, input int i);
    return $sformatf("%s[%0d]", name, i);
  endfunction

  // Reflected CRC-16 (poly 0x8005 reversed = 0xA001), refin = refout.
  function automatic logic [15:0] model_crc(input int b, input int n, input logic [15:0] init,
                                            input logic [15:0] xo);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = init[15-k];
    for (int k = 0; k < n; k++) begin
      r = r ^ {8'h00, mem[(b + k) % 1024]};
      for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r ^ xo;
  endfunction

  task automatic run_job(input int b, input int n, input int ca, input bit pulses,
                         input bit tgt_from_model);
    logic [15:0] exp_crc [3];
    int          done_c  [3];
    bit          aborted [3];
    int          nrd     [3];
    int          nrdy    [3];
    int          rdy_c   [3];
    logic [15:0] got_out [3];
    logic        got_ok  [3];
    int          exp_rd;
    for (int i = 0; i < 3; i++) begin
      exp_crc[i] = model_crc(b, n, init_p[i], xor_p[i]);
      done_c[i]  = (n == 0) ? 1 : n + lat_p[i] + 1;
      aborted[i] = (ca > 0) && (ca <= done_c[i]);
      nrd[i] = 0; nrdy[i] = 0; rdy_c[i] = -1; got_out[i] = 'x; got_ok[i] = 1'bx;
      if (tgt_from_model) target[i] = exp_crc[i];
    end
    @(negedge clk);
    base  = b[9:0];
    len   = n[10:0];
    start = 1'b1;
    abort = 1'b0;
    for (int c = 1; c <= n + 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = pulses && (c <= n + 1) && (ca == 0 || c < ca) && ($urandom_range(0, 1) == 1);
      if (start) begin
        base = 10'($urandom);
        len  = 11'($urandom_range(1, 50));
      end
      abort = (c == ca);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (mrd[i]) begin
          check_eq(tg("rd_addr", i), 32'(maddr[i]), 32'((b + nrd[i]) % 1024));
          check_eq(tg("rd_cycle", i), c, nrd[i] + 1);
          nrd[i]++;
        end
        if (rdy[i]) begin
          nrdy[i]++;
          rdy_c[i]    = c;
          got_out[i]  = cout[i];
          got_ok[i]   = ok[i];
          hold_out[i] = cout[i];
          hold_ok[i]  = ok[i];
        end else begin
          check_eq(tg("hold_out", i), 32'(cout[i]), 32'(hold_out[i]));
          check_eq(tg("hold_ok", i), 32'(ok[i]), 32'(hold_ok[i]));
        end
        if (aborted[i] && c == ca + 1) check_eq(tg("abort_idle", i), 32'(busy[i]), 0);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_rd = aborted[i] ? ((n < ca) ? n : ca) : n;
      check_eq(tg("rd_count", i), nrd[i], exp_rd);
      check_eq(tg("rdy_count", i), nrdy[i], aborted[i] ? 0 : 1);
      check_eq(tg("end_idle", i), 32'(busy[i]), 0);
      if (!aborted[i]) begin
        check_eq(tg("rdy_cycle", i), rdy_c[i], done_c[i]);
        check_eq(tg("crc_out", i), 32'(got_out[i]), 32'(exp_crc[i]));
        check_eq(tg("crc_ok", i), 32'(got_ok[i]), 32'(exp_crc[i] == target[i]));
      end
      last_out[i]   = got_out[i];
      last_rdy_c[i] = rdy_c[i];
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq(tg({tag, "_busy"}, i), 32'(busy[i]), 0);
      check_eq(tg({tag, "_rd"}, i), 32'(mrd[i]), 0);
      check_eq(tg({tag, "_rdy"}, i), 32'(rdy[i]), 0);
      check_eq(tg({tag, "_addr"}, i), 32'(maddr[i]), 0);
      check_eq(tg({tag, "_out"}, i), 32'(cout[i]), 0);
      check_eq(tg({tag, "_ok"}, i), 32'(ok[i]), 0);
      hold_out[i] = 16'h0000;
      hold_ok[i]  = 1'b0;
    end
  endtask

  initial begin
    int b, n, ca;
    int seen;
    logic [7:0] kat [9];
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base = '0; len = '0;
    for (int i = 0; i < 3; i++) target[i] = 16'h0000;
    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
    kat = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int a = 0; a < 9; a++) mem[a] = kat[a];

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_state("rst");
    rst_n = 1'b1;

    // Known answers "123456789".
    target[0] = 16'hB4C8; target[1] = 16'hBB3D; target[2] = 16'hB4C8;
    run_job(0, 9, 0, 1'b1, 1'b0);
    check_eq("kat_usb", 32'(last_out[0]), 32'h0000B4C8);
    check_eq("kat_arc", 32'(last_out[1]), 32'h0000BB3D);
    check_eq("kat_lat3", 32'(last_out[2]), 32'h0000B4C8);
    check_eq("kat_usb_cycle", last_rdy_c[0], 11);
    check_eq("kat_lat3_cycle", last_rdy_c[2], 13);

    // Empty run.
    for (int i = 0; i < 3; i++) target[i] = 16'h0000;
    run_job(5, 0, 0, 1'b0, 1'b0);
    check_eq("empty_out", 32'(last_out[0]), 0);
    check_eq("empty_cycle", last_rdy_c[2], 1);

    // Address wrap.
    run_job(10'h3FE, 4, 0, 1'b0, 1'b1);

    // Abort in fetch, then a mismatching rerun.
    run_job(0, 9, 4, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) target[i] = 16'h1234;
    run_job(0, 9, 0, 1'b0, 1'b0);
    check_eq("rerun_out", 32'(last_out[0]), 32'h0000B4C8);
    check_eq("rerun_ok", 32'(ok[0]), 0);

    // Randomised runs with spurious starts and occasional aborts.
    for (int t = 0; t < 30; t++) begin
      b  = $urandom_range(0, 1023);
      n  = $urandom_range(0, 40);
      ca = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n + 4) : 0;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 3; i++) target[i] = 16'($urandom);
        run_job(b, n, ca, 1'b1, 1'b0);
      end else begin
        run_job(b, n, ca, 1'b1, 1'b1);
      end
    end

    // Reset in the middle of a run discards it.
    @(negedge clk);
    base = 10'd100; len = 11'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_state("midrst");
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (rdy != 3'b000) seen++;
    end
    check_eq("midrst_no_rdy", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crc_mem_checker.md
CRC_MEM_CHECKER -- requirements
Module: crc_mem_checker

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10: memory address width.
REQ-002 The block SHALL have parameter CRC_W, default 16: CRC width.
REQ-003 The block SHALL have parameter POLY, default 16'h8005: generator polynomial, normal form.
REQ-004 The block SHALL have parameter INIT, default 16'hFFFF: CRC register preset.
REQ-005 The block SHALL have parameter XOR_OUT, default 16'hFFFF: final XOR mask.
REQ-006 The block SHALL have parameter REFLECT, default 1: 1 = reflect input bytes and output CRC, 0 = no reflection.
REQ-007 The block SHALL have parameter MEM_LAT, default 1, range 1..4: memory read latency in cycles.
REQ-008 The block SHALL have port clk50m, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-010 The block SHALL have port crc_start, input, 1 bit: start request, sampled in IDLE only.
REQ-011 The block SHALL have port base_addr, input, ADDR_W bits: first byte address, latched at start.
REQ-012 The block SHALL have port length, input, ADDR_W+1 bits: byte count 0..2^ADDR_W, latched at start.
REQ-013 The block SHALL have port crc_target, input, CRC_W bits: expected CRC, sampled in the DONE cycle.
REQ-014 The block SHALL have port abort, input, 1 bit: cancels the current run.
REQ-015 The block SHALL have port mem_data, input, 8 bits: read data, valid MEM_LAT cycles after mem_rd.
REQ-016 The block SHALL have port mem_addr, output, ADDR_W bits: read address.
REQ-017 The block SHALL have port mem_rd, output, 1 bit: read strobe.
REQ-018 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-019 The block SHALL have port crc_rdy, output, 1 bit: one-cycle completion pulse.
REQ-020 The block SHALL have port crc_ok, output, 1 bit: comparison result, held.
REQ-021 The block SHALL have port crc_out, output, CRC_W bits: final CRC, held.

Function
REQ-022 The FSM SHALL have exactly the states IDLE, FETCH, DRAIN and DONE.
REQ-023 IDLE: on crc_start=1 with length≠0, the block SHALL latch base_addr and length, preset the CRC register to INIT, zero the issue count and go to FETCH; with length=0 it SHALL go directly to DONE.
REQ-024 FETCH: the block SHALL drive mem_rd=1 with mem_addr = base + issue count, one byte per cycle, with no gaps; after the issue for byte length-1 it SHALL go to DRAIN.
REQ-025 mem_addr SHALL wrap modulo 2^ADDR_W; base_addr=2^ADDR_W-1 with length=2 reads the last address, then address 0.
REQ-026 A MEM_LAT-deep valid shift register fed by mem_rd SHALL qualify mem_data; the CRC SHALL update once per qualified byte, in issue order.
REQ-027 DRAIN: mem_rd SHALL be 0; when the last qualified byte has been absorbed, the block SHALL go to DONE.
REQ-028 DONE: for one cycle the block SHALL register crc_out = (REFLECT ? reflect(crc) : crc) ^ XOR_OUT and crc_ok = (that value == crc_target), pulse crc_rdy=1 aligned with the new crc_out/crc_ok, then go to IDLE.
REQ-029 Latency: with crc_start sampled at edge 0 and length=N>0, mem_rd SHALL be high in cycles 1..N and crc_rdy SHALL be high in cycle N+MEM_LAT+1; for N=0, crc_rdy SHALL be high in cycle 1.
REQ-030 crc_start while busy=1 SHALL be ignored, with no queuing.
REQ-031 crc_start in the DONE cycle SHALL be ignored; the earliest accepted restart is the first IDLE cycle, so back-to-back runs are separated by one idle cycle.
REQ-032 abort=1 in FETCH, DRAIN or DONE SHALL force IDLE at the next edge, clear the valid pipe and mem_rd, suppress crc_rdy, and leave crc_out/crc_ok at their previous values.
REQ-033 abort SHALL have priority over every other transition, including DONE -> IDLE with crc_rdy.
REQ-034 crc_out and crc_ok SHALL change only in DONE and SHALL hold otherwise.
REQ-035 The CRC update SHALL be MSB-first over the (optionally reflected) byte, modulo POLY, with all arithmetic truncated to CRC_W bits.

Reset
REQ-036 rst_n=0 at a clock edge SHALL force IDLE, crc_out=0, crc_ok=0, crc_rdy=0, mem_rd=0, busy=0, mem_addr=0, CRC register=INIT, and a cleared valid pipe.
REQ-037 Reset mid-run SHALL discard the run with no crc_rdy pulse.
REQ-038 Reset SHALL have no asynchronous path.

Structure
REQ-039 Package crc_pkg SHALL hold the FSM state enum, the USB-16 default constants (POLY/INIT/XOR_OUT) and the reflect and byte-update functions.
REQ-040 One sub-module, crc_byte_engine (clear/enable/data_in -> crc register, parametrised as above), SHALL hold the CRC register; the FSM, address counter, valid pipe and compare stay in the top level.

Verification
REQ-041 Bench: "123456789" at base 0, N=9, defaults, target 16'hB4C8 -> crc_out=16'hB4C8, crc_ok=1, crc_rdy in cycle 11.
REQ-042 Bench: same data, REFLECT=1, INIT=0, XOR_OUT=0 (ARC) -> crc_out=16'hBB3D.
REQ-043 Bench: N=0, target 0 -> crc_rdy in cycle 1, crc_out=16'h0000, crc_ok=1, no mem_rd.
REQ-044 Bench: base 10'h3FE, N=4 -> mem_addr sequence 3FE, 3FF, 000, 001.
REQ-045 Bench: abort in FETCH at byte 3 -> idle next cycle, no crc_rdy, crc_out unchanged; then a new start with target 16'h1234 on the 9-byte data -> crc_out=16'hB4C8, crc_ok=0.
REQ-046 Bench: MEM_LAT=3, N=9 -> crc_rdy in cycle 13; crc_start pulses while busy are ignored.
